// File: rtl/elbeth_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake, and feeds IF/ID.
// Outputs are combinational off state/regs/inputs, so a tied-high imem_ready gives zero-cycle fetch.
module elbeth_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_stall_req
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] hold_instr;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = ex_target & 32'hFFFF_FFFC;
  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_instr <= '0;
      state      <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          req_addr <= pc;
          if (ex_redirect) begin
            pc <= target;
            // A request that has not fired must still complete before refetching.
            if (!imem_ready) state <= DRAIN;
          end else if (imem_ready) begin
            if (ctrl_stall) begin
              hold_instr <= imem_rdata;
              state      <= HOLD;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (ex_redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!ctrl_stall) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (ex_redirect) pc <= target;
          if (imem_ready) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = pc;
    if_valid       = 1'b0;
    if_instruction = BUBBLE;
    if_pc          = '0;
    if_stall_req   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req     = 1'b1;
          imem_addr    = pc;
          if_stall_req = !imem_ready;
          if (!ex_redirect && imem_ready && !ctrl_stall) begin
            if_valid       = 1'b1;
            if_instruction = imem_rdata;
            if_pc          = pc;
          end
        end
        HOLD: begin
          if (!ex_redirect) begin
            if_valid       = 1'b1;
            if_instruction = hold_instr;
            if_pc          = pc;
          end
        end
        DRAIN: begin
          imem_req     = 1'b1;
          imem_addr    = req_addr;
          if_stall_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
